// File: rtl/io_pkg.sv
// io_pkg: shared FSM state type and default debounce depth for the input conditioner
package io_pkg;
  typedef enum logic [1:0] {INIT, STABLE, SETTLE} io_state_t;
  localparam int IO_DEBOUNCE_DEFAULT = 4;
endpackage

// File: rtl/io_sync.sv
// io_sync: two-flop synchroniser for asynchronous pin levels
module io_sync #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] sync1;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: debounces PIN into E and flags committed changes via IRQ/CHANGED
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] PIN,
  input  logic         ACK,
  output logic [N-1:0] E,
  output logic         READY,
  output logic         IRQ,
  output logic [N-1:0] CHANGED
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  io_state_t     state;
  logic [N-1:0]  sync2;
  logic [N-1:0]  cand;
  logic [CW-1:0] cnt;
  io_sync #(.N(N)) u_sync (.CLK(CLK), .RESET(RESET), .d(PIN), .q(sync2));
  // ACK clears first; a commit later in the same cycle overrides it so the new event wins
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= INIT;
      cand    <= '0;
      cnt     <= '0;
      E       <= '0;
      CHANGED <= '0;
      IRQ     <= 1'b0;
      READY   <= 1'b0;
    end else begin
      if (ACK) begin
        IRQ     <= 1'b0;
        CHANGED <= '0;
      end
      case (state)
        INIT: begin
          if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
          end else if (cnt == LAST) begin
            E     <= cand;
            READY <= 1'b1;
            state <= STABLE;
          end else cnt <= cnt + CW'(1);
        end
        STABLE: begin
          if (sync2 != E) begin
            cand  <= sync2;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
          end else if (cnt != LAST) cnt <= cnt + CW'(1);
          else begin
            state <= STABLE;
            if (cand != E) begin
              E       <= cand;
              CHANGED <= (ACK ? '0 : CHANGED) | (E ^ cand);
              IRQ     <= 1'b1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: table vectors, corner sequences and random run against a run-length model
module tb_io_input_conditioner;
  localparam int D = 4;
  logic       CLK = 0, RESET = 1, ACK = 0, READY, IRQ;
  logic [7:0] PIN = 0, E, CHANGED;
  int errs = 0, checks = 0;

  io_input_conditioner #(.N(8), .DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .RESET(RESET), .PIN(PIN), .ACK(ACK),
    .E(E), .READY(READY), .IRQ(IRQ), .CHANGED(CHANGED)
  );

  always #5 CLK = ~CLK;

  // Model: a value is committed once it has been the synchronised sample for D+1 consecutive edges
  logic [7:0] dly[$];
  logic [7:0] run_val, m_e, m_ch;
  int         run_len;
  logic       m_rdy, m_irq;

  task automatic model();
    logic [7:0] v;
    if (RESET) begin
      dly = '{8'h00, 8'h00};
      run_val = 0; run_len = 1;
      m_e = 0; m_ch = 0; m_rdy = 0; m_irq = 0;
      return;
    end
    v = dly.pop_front();
    dly.push_back(PIN);
    if (v == run_val) run_len = (run_len > D + 1) ? run_len : run_len + 1;
    else begin run_val = v; run_len = 1; end
    if (ACK) begin m_irq = 0; m_ch = 0; end
    if (run_len == D + 1) begin
      if (!m_rdy) begin m_e = v; m_rdy = 1; end
      else if (v != m_e) begin
        m_ch = m_ch | (v ^ m_e);
        m_e = v;
        m_irq = 1;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model();
    @(negedge CLK);
    chk("model_E", E, m_e);
    chk("model_READY", READY, m_rdy);
    chk("model_IRQ", IRQ, m_irq);
    chk("model_CHANGED", CHANGED, m_ch);
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic ack_pulse();
    ACK = 1; tick(); ACK = 0;
  endtask

  typedef struct {
    int         reps;
    logic       rst;
    logic [7:0] pin, e;
    logic       rdy, irq;
    logic [7:0] ch;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(int reps, logic rst, logic [7:0] pin, logic [7:0] e,
                              logic rdy, logic irq, logic [7:0] ch);
    vec_t t;
    t.reps = reps; t.rst = rst; t.pin = pin; t.e = e; t.rdy = rdy; t.irq = irq; t.ch = ch;
    return t;
  endfunction

  initial begin
    tv.push_back(mk(2, 1, 8'hA5, 8'h00, 0, 0, 8'h00));
    tv.push_back(mk(6, 0, 8'hA5, 8'h00, 0, 0, 8'h00));
    tv.push_back(mk(1, 0, 8'hA5, 8'hA5, 1, 0, 8'h00));
    tv.push_back(mk(1, 1, 8'h00, 8'h00, 0, 0, 8'h00));
    tv.push_back(mk(3, 0, 8'h00, 8'h00, 0, 0, 8'h00));
    tv.push_back(mk(1, 0, 8'h00, 8'h00, 1, 0, 8'h00));
    tv.push_back(mk(6, 0, 8'h01, 8'h00, 1, 0, 8'h00));
    tv.push_back(mk(1, 0, 8'h01, 8'h01, 1, 1, 8'h01));
    @(negedge CLK);
    foreach (tv[i]) begin
      for (int r = 0; r < tv[i].reps; r++) begin
        RESET = tv[i].rst; PIN = tv[i].pin;
        tick();
        chk("tv_E", E, tv[i].e);
        chk("tv_READY", READY, tv[i].rdy);
        chk("tv_IRQ", IRQ, tv[i].irq);
        chk("tv_CHANGED", CHANGED, tv[i].ch);
      end
    end
    ack_pulse();
    chk("ack_clear_irq", IRQ, 0);
    chk("ack_clear_ch", CHANGED, 0);
    PIN = 8'h00; hold(8);
    chk("back0_E", E, 8'h00);
    ack_pulse();
    PIN = 8'h10; hold(2);
    PIN = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_E", E, 8'h00);
      chk("glitch_IRQ", IRQ, 0);
    end
    ack_pulse();
    chk("ack_idle_E", E, 8'h00);
    chk("ack_idle_IRQ", IRQ, 0);
    PIN = 8'h01; hold(8);
    PIN = 8'h03; hold(8);
    chk("two_E", E, 8'h03);
    chk("two_IRQ", IRQ, 1);
    chk("two_CH", CHANGED, 8'h03);
    ack_pulse();
    chk("two_ack_IRQ", IRQ, 0);
    chk("two_ack_CH", CHANGED, 8'h00);
    PIN = 8'h83; hold(6);
    chk("pre_commit_E", E, 8'h03);
    ack_pulse();
    chk("race_E", E, 8'h83);
    chk("race_IRQ", IRQ, 1);
    chk("race_CH", CHANGED, 8'h80);
    PIN = 8'h00; hold(8);
    ack_pulse();
    chk("pre_rst_E", E, 8'h00);
    PIN = 8'hFF; hold(4);
    RESET = 1; hold(2); RESET = 0;
    chk("rst_E", E, 8'h00);
    chk("rst_IRQ", IRQ, 0);
    chk("rst_READY", READY, 0);
    for (int i = 0; i < 20 && !READY; i++) tick();
    chk("rst_ready_rise", READY, 1);
    chk("rst_ready_E", E, 8'hFF);
    chk("rst_ready_IRQ", IRQ, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) PIN = 8'($urandom);
      ACK = ($urandom_range(7) == 0);
      RESET = ($urandom_range(99) == 0);
      tick();
    end
    ACK = 0; RESET = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 SHALL have parameter N, default 8, data width matching the cpu E/S port width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, minimum 2, meaning consecutive stable synchronised samples required to commit.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port PIN  input  N  raw asynchronous switch/pin levels.
REQ-006 SHALL have port E  output  N  debounced, committed input word driven to the cpu E port.
REQ-007 SHALL have port READY  output  1  high once the initial E value has been committed after reset.
REQ-008 SHALL have port IRQ  output  1  pending-change flag; replaces the cpu-side input-change detect.
REQ-009 SHALL have port CHANGED  output  N  sticky mask of E bits that changed since the last ACK.
REQ-010 SHALL have port ACK  input  1  single-cycle acknowledge from the cpu; clears IRQ and CHANGED.

Function
REQ-011 SHALL pass PIN through a two-flop synchroniser (sync1, sync2); only sync2 feeds the FSM.
REQ-012 SHALL implement FSM states INIT, STABLE and SETTLE, plus a candidate register CAND[N] and a counter CNT of width $clog2(DEBOUNCE_CYCLES).
REQ-013 In INIT:
- if sync2 != CAND: CAND<=sync2, CNT<=0.
- otherwise CNT increments.
- when CNT==DEBOUNCE_CYCLES-1 and sync2==CAND: E<=CAND, READY<=1, go to STABLE.
- this commit SHALL NOT raise IRQ.
REQ-014 In STABLE, if sync2 != E: CAND<=sync2, CNT<=0, go to SETTLE; otherwise hold.
REQ-015 In SETTLE:
- if sync2 != CAND: CAND<=sync2, CNT<=0 (glitch restart).
- else if CNT<DEBOUNCE_CYCLES-1: CNT increments.
- else: commit and go to STABLE.
REQ-016 On a SETTLE commit with CAND != E:
- E<=CAND.
- CHANGED<=CHANGED | (E^CAND).
- IRQ<=1.
REQ-017 On a SETTLE commit with CAND==E (pin bounced back), E, IRQ and CHANGED SHALL be unchanged.
REQ-018 Latency: a PIN change held steady, first sampled at edge 0 with FSM in STABLE, SHALL appear on E and IRQ after edge DEBOUNCE_CYCLES+2.
REQ-019 ACK with no commit in the same cycle SHALL clear IRQ and CHANGED on the next edge.
REQ-020 ACK coinciding with a commit SHALL leave IRQ=1 and CHANGED equal to only the newly changed bits (new event wins).
REQ-021 ACK while IRQ=0 SHALL have no effect.
REQ-022 IRQ SHALL remain high until acknowledged; further commits only OR additional bits into CHANGED.
REQ-023 Outputs SHALL be registered; there SHALL be no combinational path from PIN or ACK to any output.

Reset
REQ-024 On RESET high at a rising edge:
- sync1, sync2, CAND, CNT, E, CHANGED <= 0.
- IRQ, READY <= 0.
- state <= INIT.
REQ-025 RESET asserted mid-SETTLE SHALL discard the pending candidate without raising IRQ.
REQ-026 RESET SHALL take priority over ACK and all FSM activity.

Structure
REQ-027 The state enum (INIT, STABLE, SETTLE) and the default debounce constant SHALL live in shared package io_pkg.
REQ-028 The two-flop synchroniser SHALL be a separate sub-module io_sync, parameterised by N, reset by RESET.
REQ-029 The FSM, counter, CAND, CHANGED and IRQ logic SHALL reside in io_input_conditioner.

Verification (N=8, DEBOUNCE_CYCLES=4)
REQ-030 Reset with PIN=8'hA5 held -> E=0, READY=0 until READY rises; then E=8'hA5, IRQ=0.
REQ-031 From STABLE E=8'h00, PIN->8'h01 at edge 0 and held -> E=8'h01, IRQ=1, CHANGED=8'h01 after edge 6.
REQ-032 PIN toggles 8'h00->8'h10 for 2 cycles then back to 8'h00 -> E stays 8'h00, IRQ stays 0.
REQ-033 Two commits, 8'h00->8'h01 then ->8'h03, no ACK -> IRQ=1, CHANGED=8'h03; ACK pulse -> IRQ=0, CHANGED=0 next edge.
REQ-034 ACK pulsed on the same edge as commit 8'h03->8'h83 -> IRQ=1, CHANGED=8'h80.
REQ-035 RESET asserted 2 cycles into SETTLE (E=8'h00, PIN=8'hFF) -> IRQ=0, E=0, state INIT; READY then rises with E=8'hFF.
